// File: rtl/sobel_stream.sv
// -----------------------------------------------------------------------------
// sobel_stream
//
// Streaming 3x3 Sobel edge detector for raster-order pixel streams. Two line
// buffers hold the previous two input rows. A 3x3 window register holds the
// newest three columns. Two arithmetic stages follow the window:
//   p0 : window (3 columns x 3 rows) plus the window-valid flag and row markers
//   p1 : signed Gx / Gy
//   p2 : output register (|Gx|+|Gy| saturated, or thresholded to binary)
// The output is the cropped (IMG_W-2)x(IMG_H-2) gradient image.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   start_i      frame start pulse, honoured only in IDLE
//   mode_i       0 = saturated magnitude, 1 = binary threshold (latched at start)
//   threshold_i  binary threshold (latched at start)
//   in_valid_i   input pixel valid
//   in_ready_o   block accepts an input pixel this cycle
//   in_pixel_i   input pixel, unsigned, raster order
//   out_valid_o  output pixel valid
//   out_ready_i  downstream accepts the output pixel
//   out_pixel_o  result pixel
//   out_eol_o    last pixel of an output row
//   out_last_o   last pixel of the output frame
//   busy_o       frame in progress (RUN or DRAIN)
//   done_o       one-cycle pulse after the final output handshake
// -----------------------------------------------------------------------------
module sobel_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic [DATA_WIDTH+3:0] threshold_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_pixel_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_pixel_o,
    output logic                  out_eol_o,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int GW = DATA_WIDTH + 3;
    localparam int SW = DATA_WIDTH + 4;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [SW-1:0] PIX_MAX  = SW'((1 << DATA_WIDTH) - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    // ---------------------------------------------------------------- helpers
    function automatic logic signed [GW-1:0] f_ext(input logic [DATA_WIDTH-1:0] p);
        return $signed({3'b000, p});
    endfunction

    // (b0 + 2*b1 + b2) - (a0 + 2*a1 + a2); magnitude never exceeds 4*max pixel
    function automatic logic signed [GW-1:0] f_grad(
        input logic [DATA_WIDTH-1:0] a0, input logic [DATA_WIDTH-1:0] a1,
        input logic [DATA_WIDTH-1:0] a2, input logic [DATA_WIDTH-1:0] b0,
        input logic [DATA_WIDTH-1:0] b1, input logic [DATA_WIDTH-1:0] b2);
        logic signed [GW-1:0] sa;
        logic signed [GW-1:0] sb;
        sa = f_ext(a0) + (f_ext(a1) <<< 1) + f_ext(a2);
        sb = f_ext(b0) + (f_ext(b1) <<< 1) + f_ext(b2);
        return sb - sa;
    endfunction

    function automatic logic [SW-1:0] f_abs(input logic signed [GW-1:0] g);
        logic signed [GW-1:0] m;
        m = g[GW-1] ? -g : g;
        return {1'b0, m};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_sat(input logic [SW-1:0] s);
        return (s > PIX_MAX) ? {DATA_WIDTH{1'b1}} : s[DATA_WIDTH-1:0];
    endfunction

    // Edges are dark; equality is treated as no edge
    function automatic logic [DATA_WIDTH-1:0] f_bin(input logic [SW-1:0] s,
                                                    input logic [SW-1:0] thr);
        return (s > thr) ? {DATA_WIDTH{1'b0}} : {DATA_WIDTH{1'b1}};
    endfunction

    // ---------------------------------------------------------------- control
    logic [1:0]            r_state;
    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic                  r_mode;
    logic [SW-1:0]         r_thr;
    logic                  r_done;
    logic                  r_vld_p0;
    logic                  r_vld_p1;
    logic                  r_vld_p2;

    // ---------------------------------------------------------------- data
    logic [DATA_WIDTH-1:0] r_lb0 [IMG_W];
    logic [DATA_WIDTH-1:0] r_lb1 [IMG_W];
    logic [DATA_WIDTH-1:0] r_top_p0 [3];
    logic [DATA_WIDTH-1:0] r_mid_p0 [3];
    logic [DATA_WIDTH-1:0] r_bot_p0 [3];
    logic                  r_eol_p0;
    logic                  r_last_p0;
    logic signed [GW-1:0]  r_gx_p1;
    logic signed [GW-1:0]  r_gy_p1;
    logic                  r_eol_p1;
    logic                  r_last_p1;
    logic [DATA_WIDTH-1:0] r_pix_p2;
    logic                  r_eol_p2;
    logic                  r_last_p2;

    logic                  w_en;
    logic                  w_hs;
    logic                  w_win_ok;
    logic                  w_col_last;
    logic                  w_row_last;
    logic [SW-1:0]         w_sum_p1;
    logic                  w_fin;

    assign w_en       = !r_vld_p2 || out_ready_i;
    assign in_ready_o = (r_state == RUN) && w_en;
    assign w_hs       = in_valid_i && in_ready_o;
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_win_ok   = (r_row >= ROW_TWO) && (r_col >= COL_TWO);
    assign w_sum_p1   = f_abs(r_gx_p1) + f_abs(r_gy_p1);

    // Final output leaving while nothing remains behind it in the pipe
    assign w_fin = !r_vld_p0 && !r_vld_p1 && r_vld_p2 && out_ready_i && r_last_p2;

    assign busy_o      = (r_state != IDLE);
    assign done_o      = r_done;
    assign out_valid_o = r_vld_p2;
    assign out_pixel_o = r_pix_p2;
    assign out_eol_o   = r_eol_p2;
    assign out_last_o  = r_last_p2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_mode    <= 1'b0;
            r_thr     <= '0;
            r_done    <= 1'b0;
            r_vld_p0  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_pix_p2  <= '0;
            r_eol_p2  <= 1'b0;
            r_last_p2 <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // r_done blocks a start arriving in the done cycle
                    if (start_i && !r_done) begin
                        r_state <= RUN;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_mode  <= mode_i;
                        r_thr   <= threshold_i;
                    end
                end
                RUN: begin
                    if (w_hs && w_col_last && w_row_last) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_fin) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_hs) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end

            if (w_en) begin
                r_vld_p0  <= w_hs && w_win_ok;
                r_vld_p1  <= r_vld_p0;
                r_vld_p2  <= r_vld_p1;
                // Stage p1 -> p2: magnitude / threshold
                r_pix_p2  <= r_mode ? f_bin(w_sum_p1, r_thr) : f_sat(w_sum_p1);
                r_eol_p2  <= r_vld_p1 && r_eol_p1;
                r_last_p2 <= r_vld_p1 && r_last_p1;
            end
        end
    end

    // Line buffers: lb1 holds row r-1, lb0 holds row r-2 at each column
    always_ff @(posedge clk_i) begin
        if (w_hs) begin
            r_lb0[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= in_pixel_i;
        end
    end

    // Stage in -> p0: shift window left, new column enters at index 2
    always_ff @(posedge clk_i) begin
        if (w_hs) begin
            r_top_p0[0] <= r_top_p0[1];
            r_top_p0[1] <= r_top_p0[2];
            r_top_p0[2] <= r_lb0[r_col];
            r_mid_p0[0] <= r_mid_p0[1];
            r_mid_p0[1] <= r_mid_p0[2];
            r_mid_p0[2] <= r_lb1[r_col];
            r_bot_p0[0] <= r_bot_p0[1];
            r_bot_p0[1] <= r_bot_p0[2];
            r_bot_p0[2] <= in_pixel_i;
            r_eol_p0    <= w_col_last;
            r_last_p0   <= w_col_last && w_row_last;
        end
    end

    // Stage p0 -> p1: gradients (Gx right minus left, Gy bottom minus top)
    always_ff @(posedge clk_i) begin
        if (w_en) begin
            r_gx_p1   <= f_grad(r_top_p0[0], r_mid_p0[0], r_bot_p0[0],
                                r_top_p0[2], r_mid_p0[2], r_bot_p0[2]);
            r_gy_p1   <= f_grad(r_top_p0[0], r_top_p0[1], r_top_p0[2],
                                r_bot_p0[0], r_bot_p0[1], r_bot_p0[2]);
            r_eol_p1  <= r_eol_p0;
            r_last_p1 <= r_last_p0;
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// -----------------------------------------------------------------------------
// tb_sobel_stream
//
// Two instances: a 5x4 frame (directed cases, backpressure, reset) and an 8x6
// frame (random image with random bubbles on both handshakes). Expected outputs
// come from a direct 3x3 Sobel evaluation over the stored image.
// -----------------------------------------------------------------------------
module tb_sobel_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       start     [2];
    logic       mode      [2];
    logic [11:0] thr      [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] in_pix    [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] out_pix   [2];
    logic       out_eol   [2];
    logic       out_last  [2];
    logic       busy      [2];
    logic       done      [2];

    int n_tests = 0;
    int n_fail  = 0;
    int img [64];
    int exp_q [$];

    always #5 clk = ~clk;

    sobel_stream #(.DATA_WIDTH(8), .IMG_W(5), .IMG_H(4)) u_dut_s (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .mode_i(mode[0]),
        .threshold_i(thr[0]), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .in_pixel_i(in_pix[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .out_pixel_o(out_pix[0]), .out_eol_o(out_eol[0]), .out_last_o(out_last[0]),
        .busy_o(busy[0]), .done_o(done[0]));

    sobel_stream #(.DATA_WIDTH(8), .IMG_W(8), .IMG_H(6)) u_dut_l (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .mode_i(mode[1]),
        .threshold_i(thr[1]), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .in_pixel_i(in_pix[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .out_pixel_o(out_pix[1]), .out_eol_o(out_eol[1]), .out_last_o(out_last[1]),
        .busy_o(busy[1]), .done_o(done[1]));

    task automatic check_eq(input string tag, input int got, input int expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic int px(input int w, input int x, input int y);
        return img[y * w + x];
    endfunction

    // Expected stream entry: pixel | eol<<8 | last<<9
    task automatic build_ref(input int w, input int h, input bit md, input int th);
        int gx, gy, s, o;
        exp_q.delete();
        for (int y = 1; y <= h - 2; y++) begin
            for (int x = 1; x <= w - 2; x++) begin
                gx = (px(w, x+1, y-1) + 2*px(w, x+1, y) + px(w, x+1, y+1))
                   - (px(w, x-1, y-1) + 2*px(w, x-1, y) + px(w, x-1, y+1));
                gy = (px(w, x-1, y+1) + 2*px(w, x, y+1) + px(w, x+1, y+1))
                   - (px(w, x-1, y-1) + 2*px(w, x, y-1) + px(w, x+1, y-1));
                s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                if (md) o = (s > th) ? 0 : 255;
                else    o = (s > 255) ? 255 : s;
                o = o | ((x == w - 2) ? 256 : 0) | ((x == w - 2 && y == h - 2) ? 512 : 0);
                exp_q.push_back(o);
            end
        end
    endtask

    task automatic check_idle(input int d, input string name);
        check_eq({name, " in_ready"},  int'(in_ready[d]),  0);
        check_eq({name, " out_valid"}, int'(out_valid[d]), 0);
        check_eq({name, " out_pixel"}, int'(out_pix[d]),   0);
        check_eq({name, " out_eol"},   int'(out_eol[d]),   0);
        check_eq({name, " out_last"},  int'(out_last[d]),  0);
        check_eq({name, " busy"},      int'(busy[d]),      0);
        check_eq({name, " done"},      int'(done[d]),      0);
    endtask

    task automatic drive(input int d, input int idx, input int npix, input int pin,
                         input int pout, input int hold);
        in_valid[d]  = (idx < npix) && ($urandom_range(99) < pin);
        in_pix[d]    = (idx < npix) ? 8'(img[idx]) : 8'd0;
        out_ready[d] = (hold > 0) ? 1'b0 : ($urandom_range(99) < pout);
    endtask

    task automatic run_frame(input int d, input int w, input int h, input bit md,
                             input int th, input int pin, input int pout,
                             input bit do_hold, input string name);
        int idx, k, cyc, dones, hold, held_pix;
        bit hold_used;
        build_ref(w, h, md, th);
        @(posedge clk); #1;
        start[d] = 1'b1; mode[d] = md; thr[d] = 12'(th);
        @(posedge clk); #1;
        // Change mode/threshold after the start to confirm they were latched
        start[d] = 1'b0; mode[d] = ~md; thr[d] = 12'd0;
        idx = 0; k = 0; cyc = 0; dones = 0; hold = 0; held_pix = 0; hold_used = 0;
        drive(d, idx, w * h, pin, pout, hold);
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check_eq({name, " start->in_ready"}, int'(in_ready[d]), 1);
                check_eq({name, " start->busy"},     int'(busy[d]),     1);
            end
            if (hold > 0) begin
                check_eq($sformatf("%s stall valid%0d", name, hold), int'(out_valid[d]), 1);
                check_eq($sformatf("%s stall in_ready%0d", name, hold), int'(in_ready[d]), 0);
                if (hold == 5) held_pix = int'({out_last[d], out_eol[d], out_pix[d]});
                else check_eq($sformatf("%s stall data%0d", name, hold),
                              int'({out_last[d], out_eol[d], out_pix[d]}), held_pix);
                hold--;
            end
            if (out_valid[d] && out_ready[d]) begin
                if (k < exp_q.size())
                    check_eq($sformatf("%s out%0d", name, k),
                             int'({out_last[d], out_eol[d], out_pix[d]}), exp_q[k]);
                else
                    check_eq($sformatf("%s extra output", name), k, exp_q.size() - 1);
                k++;
            end
            if (in_valid[d] && in_ready[d]) idx++;
            if (done[d]) begin
                dones++;
                check_eq({name, " outputs at done"}, k, exp_q.size());
                check_eq({name, " inputs at done"}, idx, w * h);
                check_eq({name, " busy in done cycle"}, int'(busy[d]), 0);
                break;
            end
            if (cyc >= 3000) break;
            @(posedge clk); #1;
            if (do_hold && !hold_used && k == 2) begin
                hold = 5;
                hold_used = 1;
            end
            drive(d, idx, w * h, pin, pout, hold);
        end
        check_eq({name, " done seen (timeout)"}, dones, 1);
        // A start in the done cycle must be ignored
        start[d] = 1'b1; in_valid[d] = 1'b0;
        @(posedge clk); #1;
        start[d] = 1'b0; out_ready[d] = 1'b1;
        @(negedge clk);
        check_eq({name, " done one cycle"},     int'(done[d]), 0);
        check_eq({name, " start in done ign"},  int'(busy[d]), 0);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) img[i] = int'($urandom_range(255));
    endtask

    initial begin
        int idx;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 0; mode[d] = 0; thr[d] = 0;
            in_valid[d] = 0; in_pix[d] = 0; out_ready[d] = 1;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle(0, "reset s");
        check_idle(1, "reset l");

        // Uniform frame, both modes
        for (int i = 0; i < 20; i++) img[i] = 100;
        run_frame(0, 5, 4, 1'b0, 0,  100, 100, 1'b0, "uniform mag");
        run_frame(0, 5, 4, 1'b1, 50, 100, 100, 1'b0, "uniform bin");

        // Vertical step 0 -> 200 at column 2
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 5; x++) img[y*5 + x] = (x < 2) ? 0 : 200;
        run_frame(0, 5, 4, 1'b0, 0, 100, 100, 1'b0, "vstep");

        // Step of 10 at column 2 gives s = 40 at output columns 0-1
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 5; x++) img[y*5 + x] = (x < 2) ? 50 : 60;
        run_frame(0, 5, 4, 1'b1, 40, 100, 100, 1'b0, "thr eq40");
        run_frame(0, 5, 4, 1'b1, 39, 100, 100, 1'b0, "thr eq39");

        // Backpressure: 5-cycle hold mid-frame
        fill_random(20);
        run_frame(0, 5, 4, 1'b0, 0, 100, 100, 1'b1, "bpress");

        // Random bubbles on the 8x6 frame, both modes
        for (int f = 0; f < 3; f++) begin
            fill_random(48);
            run_frame(1, 8, 6, f[0], int'($urandom_range(600)), 60, 60, 1'b0,
                      $sformatf("rand%0d", f));
        end

        // Reset after 7 accepted pixels, then a complete frame
        fill_random(20);
        @(posedge clk); #1;
        start[0] = 1'b1; mode[0] = 1'b0;
        @(posedge clk); #1;
        start[0] = 1'b0;
        idx = 0;
        in_valid[0] = 1'b1; in_pix[0] = 8'(img[0]);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (in_valid[0] && in_ready[0]) idx++;
            if (idx == 7) break;
            @(posedge clk); #1;
            in_pix[0] = 8'(img[idx]);
        end
        check_eq("rst accepted 7", idx, 7);
        @(posedge clk); #1;
        rst = 1'b1; in_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle(0, "midrst");
        fill_random(20);
        run_frame(0, 5, 4, 1'b0, 0, 80, 80, 1'b0, "after rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_stream.md
# sobel_stream

Streaming, parametrised Sobel edge detector for raster-order pixel streams. It accepts one pixel per cycle over a valid/ready handshake and keeps two line buffers plus a 3x3 window. It emits the cropped (IMG_W-2)x(IMG_H-2) gradient image in either binary-threshold or saturated-magnitude mode. It sits between the input image source and the output image writer, and it needs no random-access input memory.

## Interface
- DATA_WIDTH, 8: pixel width in bits (unsigned pixels).
- IMG_W, 640: input columns; must be at least 3.
- IMG_H, 480: input rows; must be at least 3.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- start_i  in  1  single-cycle pulse that begins a frame; only honoured in IDLE.
- mode_i  in  1  0 = magnitude, 1 = binary; sampled on an accepted start.
- threshold_i  in  DATA_WIDTH+4  binary threshold; sampled on an accepted start.
- in_valid_i  in  1  input pixel valid.
- in_ready_o  out  1  block can accept an input pixel.
- in_pixel_i  in  DATA_WIDTH  input pixel, raster order.
- out_valid_o  out  1  output pixel valid.
- out_ready_i  in  1  downstream accepts the output pixel.
- out_pixel_o  out  DATA_WIDTH  result pixel.
- out_eol_o  out  1  marks the last pixel of an output row.
- out_last_o  out  1  marks the last pixel of the frame.
- busy_o  out  1  high in RUN and DRAIN.
- done_o  out  1  one-cycle pulse when the frame completes.

## Operation
- **FSM states**
  - IDLE: on start_i, go to RUN, clear col/row counters, latch mode and threshold.
  - RUN: accept pixels; on the handshake for pixel (IMG_H-1, IMG_W-1), go to DRAIN.
  - DRAIN: wait until both pipeline stages are empty and the last output has handshaken; then pulse done_o and go to IDLE.
- start_i is ignored in RUN and DRAIN.
- **Handshakes**
  - Input handshake: in_valid_i && in_ready_o.
  - Stall enable: en = !out_valid_o || out_ready_i.
  - in_ready_o = (state==RUN) && en.
- **Counters**
  - col counts 0..IMG_W-1 and advances on each input handshake.
  - On wrap, col returns to 0 and row increments.
  - row counts 0..IMG_H-1.
- **Line buffers**
  - Two IMG_W-deep memories indexed by col: lb1 holds row r-1 and lb0 holds row r-2.
  - On each handshake: lb0[col] <= lb1[col]; lb1[col] <= pixel.
  - The 3x3 window shift registers load the column {lb0[col], lb1[col], pixel}.
- **Window validity**: the accepted pixel at (r,c) completes a valid window when r>=2 && c>=2.
  - The window is centred at (r-1,c-1).
  - Its output index is (r-2,c-2).
  - Invalid windows (border columns and the first two rows) produce no output.
- **Stage 1** (registered, enabled by en)
  - Gx = (p02+2p12+p22) - (p00+2p10+p20).
  - Gy = (p20+2p21+p22) - (p00+2p01+p02).
  - Both are signed, DATA_WIDTH+3 bits.
- **Stage 2** (registered, enabled by en)
  - s = |Gx|+|Gy|, unsigned, DATA_WIDTH+4 bits; no overflow is possible.
  - Binary mode: out = (s > threshold) ? 0 : 2^DATA_WIDTH-1. Edges are dark and equality counts as no edge.
  - Magnitude mode: out = min(s, 2^DATA_WIDTH-1).
- **Output markers**
  - out_eol_o is high for output column IMG_W-3.
  - out_last_o is high for output (IMG_H-3, IMG_W-3).
  - Both markers travel with the pixel through the pipeline.
- **Reset mid-operation**: abort the frame; the FSM goes to IDLE; counters and pipeline valids clear. Line buffer contents are don't-care.

## Timing
- **Reset values**
  - 0: in_ready_o, out_valid_o, out_pixel_o, out_eol_o, out_last_o, busy_o, done_o.
  - State is IDLE.
- Start latency: start_i accepted at edge N gives in_ready_o=1 from cycle N+1 (provided en is high).
- Pipeline latency: a window-completing input handshake at edge N gives out_valid_o high after edge N+2, when there is no stall.
- Throughput: one pixel per cycle sustained.
- **Stall**
  - While out_valid_o && !out_ready_i, all stages, counters and line buffers freeze.
  - out_pixel_o, out_eol_o and out_last_o hold stable.
  - in_ready_o is 0.
- A bubble (in_valid_i=0) propagates as an invalid stage and never produces a spurious out_valid_o.
- done_o is asserted in the cycle after the out_last_o handshake; it lasts exactly one cycle, and busy_o falls in that same cycle.
- A start_i arriving in the done_o cycle is ignored. A start_i one cycle later is accepted.

## Test plan
- **Uniform frame**: IMG_W=5, IMG_H=4, all pixels 100.
  - Magnitude mode gives exactly 6 outputs of 0, with out_eol_o on outputs 3 and 6 and out_last_o on output 6.
  - Binary mode with threshold 50 gives 6 outputs of 255.
- **Vertical step**: W=5, H=4, columns 0-1 = 0 and columns 2-4 = 200, magnitude mode.
  - Each output row is 255, 255, 0 (s=800 saturates).
  - done_o pulses once.
- **Threshold equality**: W=5, H=4, step of 10 at column 2, so s=40.
  - Threshold 40 gives 255 at output columns 0-1.
  - Threshold 39 gives 0 at output columns 0-1.
- **Backpressure**: hold out_ready_i=0 for 5 cycles mid-frame.
  - out_valid_o stays 1 with stable data and in_ready_o=0.
  - After release, the output sequence equals the no-stall reference with no loss and no duplicates.
- **Random bubbles**: toggle in_valid_i and out_ready_i randomly on an 8x6 random image.
  - The output stream matches the golden model exactly, in 24 outputs.
- **Reset mid-frame**: assert rst_i after 7 accepted pixels.
  - All outputs return to 0 and the FSM is in IDLE.
  - A new start_i with a full frame then produces correct results.
